// File: rtl/bcd_count_ctrl.sv
// bcd_count_ctrl: run/stop BCD event counter sequencing an external combinational incrementor.
// Optional load validation enabled by defining BCD_CNT_VALID_CHECK_EN.
module bcd_count_ctrl #(
  parameter int PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load,
  input  logic [11:0] load_value,
  input  logic [11:0] limit,
  output logic [11:0] bcd_inc_in,
  input  logic [11:0] bcd_inc_out,
  output logic [11:0] count,
  output logic        running,
  output logic        done,
  output logic        wrap,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  state_t      state_q;
  logic [11:0] count_q;
  logic [15:0] pre_q;
  logic        wrap_q, err_q;
  logic        tick, load_ok;
  assign tick = state_q == RUN && pre_q == PRE_MAX;
`ifdef BCD_CNT_VALID_CHECK_EN
  assign load_ok = load_value[3:0] < 4'd10 && load_value[7:4] < 4'd10 && load_value[11:8] < 4'd10;
`else
  assign load_ok = 1'b1;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      pre_q   <= '0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
      if (clear) begin
        count_q <= '0;
        state_q <= IDLE;
        pre_q   <= '0;
      end else if (load) begin
        if (load_ok) begin
          count_q <= load_value;
          pre_q   <= '0;
          if (state_q != RUN) state_q <= IDLE;
        end else err_q <= 1'b1;
      end else if (stop) begin
        if (state_q == RUN) begin
          state_q <= IDLE;
          pre_q   <= '0;
        end
      end else if (start) begin
        if (state_q == IDLE) begin
          state_q <= RUN;
          pre_q   <= '0;
        end
      end else if (tick) begin
        count_q <= bcd_inc_out;
        pre_q   <= '0;
        wrap_q  <= count_q == 12'h999;
        if (bcd_inc_out == limit) state_q <= DONE;
      end else if (state_q == RUN) pre_q <= pre_q + 16'd1;
    end
  end
  assign bcd_inc_in = count_q;
  assign count      = count_q;
  assign running    = state_q == RUN;
  assign done       = state_q == DONE;
  assign wrap       = wrap_q;
  assign err        = err_q;
endmodule

// File: doc/bcd_count_ctrl.md
# bcd_count_ctrl

Controller that sequences the existing 3-digit combinational BCD incrementor into a run/stop event counter with a programmable terminal value. Owns the count register, drives the incrementor's input, and captures its output on prescaled ticks. Sits between front-panel command logic (buttons/debouncers) and the 7-segment display driver, which reads `count` directly.

## Interface
- `PRESCALE`, default 4: clock cycles per count tick while running; legal range 1..65535.
- `clk` input 1: system clock, all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle command, begin counting.
- `stop` input 1: single-cycle command, halt counting and keep the count.
- `clear` input 1: single-cycle command, count to 000 and return to idle.
- `load` input 1: single-cycle command, load `load_value` into the count.
- `load_value` input 12: BCD value for `load`, hundreds in [11:8].
- `limit` input 12: BCD terminal value, sampled on every tick.
- `bcd_inc_in` output 12: driven continuously from the count register; goes to the incrementor's input.
- `bcd_inc_out` input 12: incrementor result, combinational from `bcd_inc_in`.
- `count` output 12: current BCD count.
- `running` output 1: high in the RUN state.
- `done` output 1: level, high in the DONE state.
- `wrap` output 1: one-cycle pulse on 999 -> 000.
- `err` output 1: one-cycle pulse when a load is rejected. Only active with `BCD_CNT_VALID_CHECK_EN`.

## Operation
- States:
  - IDLE: reset state.
  - RUN
  - DONE
- Command priority, highest first: `rst` > `clear` > `load` > `stop` > `start` > tick. Only the highest active event acts in a cycle.
- `clear` (any state): count=000, state=IDLE, prescaler=0.
- `load` (any state):
  - count=`load_value`, prescaler=0.
  - RUN stays RUN.
  - DONE and IDLE both go to IDLE.
- `stop`:
  - RUN -> IDLE; count is held, prescaler=0.
  - Ignored in IDLE and DONE.
- `start`:
  - IDLE -> RUN, prescaler=0.
  - Ignored in RUN.
  - Ignored in DONE; `clear` or `load` is required first.
- Prescaler counts 0..PRESCALE-1 in RUN only.
  - tick = RUN && prescaler==PRESCALE-1.
  - The prescaler returns to 0 on the tick.
- On a tick:
  - count <= `bcd_inc_out`.
  - If `bcd_inc_out` == `limit`, state -> DONE in the same edge.
  - If count was 999, `wrap` is asserted for the next cycle. The incrementor yields 000.
- Start with count already equal to `limit`: the counter does not stop immediately. It runs until the count returns to `limit` (1000 ticks).
- `limit`=000: the counter counts to 999, wraps to 000, then enters DONE. `wrap` and `done` rise on the same edge.
- `limit` containing a non-BCD digit: never matches, so the counter free-runs and wraps.

## Timing
- Reset values: `count`=000, `bcd_inc_in`=000, `running`=0, `done`=0, `wrap`=0, `err`=0, state=IDLE, prescaler=0.
- Commands sampled at edge k take effect in registered outputs after edge k.
- `start` at edge k: first increment at edge k+PRESCALE, then one increment every PRESCALE cycles.
- PRESCALE=1: increments every cycle in RUN, first at edge k+1.
- `bcd_inc_out` is used in the same cycle `bcd_inc_in` is presented. There is no pipeline stage; the total path is register -> incrementor -> register.
- `running` and `done` are decoded from the state register and update on the state-change edge.
- `wrap` and `err` are registered one-cycle pulses. Back-to-back wraps (PRESCALE=1, count 999 with `load` repeating) produce separate pulses.
- `rst` during RUN: all outputs return to reset values after that edge. A pending command in that cycle is discarded.

## Configuration
- `BCD_CNT_VALID_CHECK_EN` defined:
  - `load` with any nibble of `load_value` > 9 is rejected.
  - On rejection, count, state and prescaler are unchanged, and `err` pulses one cycle.
  - A rejected `load` still blocks lower-priority commands in that cycle.
- Not defined:
  - `err` is tied to 0.
  - `load_value` is loaded unchecked.
  - Subsequent incrementor behaviour on non-BCD digits is not guaranteed by this block.

## Test plan
- Reset, PRESCALE=4, `start`, `limit`=010 -> count 001 at 4 cycles after start, then +1 every 4 cycles. Count reaches 010 at 40 cycles; `done`=1, `running`=0, count holds 010.
- `load` 259, `limit`=300, `start`, then `stop` after 3 ticks -> count 262 and holds in IDLE. A second `start` resumes and the next value is 263.
- `load` 998, `limit`=005, PRESCALE=1, `start` -> count sequence 999, 000, 001…; `wrap` pulses once on the 999->000 edge; `done` at 005.
- Same cycle `clear`+`load`+`start` while in RUN at 123 -> count 000, IDLE; `load` and `start` are ignored.
- `load` 1A3 (hex nibble A) with the macro defined -> count unchanged, `err` 1-cycle pulse. Without the macro -> count=1A3, `err`=0.
- `rst` asserted mid-RUN at count 047 -> next cycle: count 000, `running` 0, `done` 0, `wrap` 0, `bcd_inc_in` 000.
